// File: rtl/led_scan_pkg.sv
// Shared types and constants for the LED scan controller.
package led_scan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_BLANK,
    ST_HOLD
  } state_e;

  localparam logic [2:0] G_ON   = 3'b001;
  localparam logic [2:0] G_OFF  = 3'b000;
  localparam int         ADDR_W = 4;

endpackage

// File: rtl/led_scan_ctrl_dwell_timer.sv
// Dwell counter: counts while run_i is high and flags the last cycle of a dwell.
module dwell_timer #(
  parameter int DWELL = 25_000_000,
  parameter int CNT_W = 25
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic run_i,
  input  logic clr_i,
  output logic done_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             at_end;

  assign at_end = (cnt_q == CNT_W'(DWELL - 1));
  assign done_o = run_i && at_end;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (run_i) begin
      cnt_d = at_end ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/led_scan_ctrl.sv
// Sweeps one lit LED across a 4-to-16 decoder pair, with blanking, hold and load.
// Optional build macro LED_SCAN_BOUNCE_EN selects a ping-pong sweep instead of modulo-16.
module led_scan_ctrl
  import led_scan_pkg::*;
#(
  parameter int DWELL = 25_000_000,
  parameter int CNT_W = 25
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              stop_i,
  input  logic              dir_i,
  input  logic              load_valid_i,
  input  logic [ADDR_W-1:0] load_addr_i,
  output logic              load_ready_o,
  input  logic              release_i,
  output logic [ADDR_W-1:0] swt_o,
  output logic [2:0]        g1_o,
  output logic [2:0]        g2_o,
  output logic              wrap_o,
  output logic              busy_o
);

  state_e            state_q;
  logic [ADDR_W-1:0] swt_q;
  logic [2:0]        g_q;
  logic              wrap_q;
  logic              busy_q;
  logic              load_fire;
  logic              dwell_done;
  logic [ADDR_W-1:0] step_addr_d;
  logic              step_wrap_d;
`ifdef LED_SCAN_BOUNCE_EN
  logic              dir_q;
  logic              step_dir_d;
`endif

  assign load_ready_o = (state_q != ST_BLANK);
  assign load_fire    = load_valid_i && load_ready_o;

  // Counter only runs in RUN; leaving RUN for any reason restarts the dwell.
  dwell_timer #(
    .DWELL(DWELL),
    .CNT_W(CNT_W)
  ) u_dwell (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .run_i (state_q == ST_RUN),
    .clr_i ((state_q != ST_RUN) || stop_i || load_fire),
    .done_o(dwell_done)
  );

  always_comb begin
    step_addr_d = swt_q + 1'b1;
    step_wrap_d = (swt_q == '1);
`ifdef LED_SCAN_BOUNCE_EN
    step_dir_d  = dir_q;
    if (!dir_q) begin
      if (swt_q == '1) begin
        step_addr_d = swt_q - 1'b1;
        step_dir_d  = 1'b1;
      end
    end else begin
      step_addr_d = swt_q - 1'b1;
      step_wrap_d = (swt_q == '0);
      if (swt_q == '0) begin
        step_addr_d = swt_q + 1'b1;
        step_dir_d  = 1'b0;
      end
    end
`else
    if (dir_i) begin
      step_addr_d = swt_q - 1'b1;
      step_wrap_d = (swt_q == '0);
    end
`endif
  end

  // Control priority: stop, then load, then per-state events.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      swt_q   <= '0;
      g_q     <= G_OFF;
      wrap_q  <= 1'b0;
      busy_q  <= 1'b0;
`ifdef LED_SCAN_BOUNCE_EN
      dir_q   <= 1'b0;
`endif
    end else begin
      wrap_q <= 1'b0;
      if (stop_i) begin
        state_q <= ST_IDLE;
        g_q     <= G_OFF;
        busy_q  <= 1'b0;
      end else if (load_fire) begin
        state_q <= ST_HOLD;
        swt_q   <= load_addr_i;
        g_q     <= G_ON;
        busy_q  <= 1'b1;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (start_i) begin
              state_q <= ST_RUN;
              g_q     <= G_ON;
              busy_q  <= 1'b1;
`ifdef LED_SCAN_BOUNCE_EN
              dir_q   <= dir_i;
`endif
            end
          end
          ST_RUN: begin
            if (dwell_done) begin
              state_q <= ST_BLANK;
              g_q     <= G_OFF;
            end
          end
          ST_BLANK: begin
            state_q <= ST_RUN;
            g_q     <= G_ON;
            swt_q   <= step_addr_d;
            wrap_q  <= step_wrap_d;
`ifdef LED_SCAN_BOUNCE_EN
            dir_q   <= step_dir_d;
`endif
          end
          ST_HOLD: begin
            if (release_i) begin
              state_q <= ST_RUN;
`ifdef LED_SCAN_BOUNCE_EN
              dir_q   <= dir_i;
`endif
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign swt_o  = swt_q;
  assign g1_o   = g_q;
  assign g2_o   = g_q;
  assign wrap_o = wrap_q;
  assign busy_o = busy_q;

endmodule
